// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared encodings for the custom I/O chip update scheduler.
// Revision : 1.0
// ============================================================================
package io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_QUIET = 3'd1,
        ST_UPD0       = 3'd2,
        ST_GAP0       = 3'd3,
        ST_UPD1       = 3'd4,
        ST_GAP1       = 3'd5
    } io_state_t;

    localparam logic CHIP0 = 1'b0;
    localparam logic CHIP1 = 1'b1;

    localparam logic [7:0] IDLE_READ = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/io_quiet_timer.sv
`default_nettype none
// ============================================================================
// Module   : io_quiet_timer
// Purpose  : Counts CPU-idle cycles and total wait cycles; fires when either
//            the quiet window or the timeout limit is reached.
// Revision : 1.0
// ============================================================================
module io_quiet_timer
    import io_pkg::*;
#(
    parameter int HOLDOFF = 4,
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_cpu_active,
    output logic o_fire
);

    localparam int QW = $clog2(HOLDOFF + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [QW-1:0] c_QUIET_LAST = QW'(HOLDOFF - 1);
    localparam logic [TW-1:0] c_TO_LAST    = TW'(TIMEOUT - 1);

    logic [QW-1:0] r_quiet;
    logic [TW-1:0] r_timeout;
    logic          w_quiet_hit;
    logic          w_timeout_hit;

    always_ff @(posedge CLK) begin
        if (RESET || i_clear) begin
            r_quiet   <= '0;
            r_timeout <= '0;
        end else if (i_enable) begin
            if (i_cpu_active)
                r_quiet <= '0;
            else if (r_quiet != c_QUIET_LAST)
                r_quiet <= r_quiet + QW'(1);
            if (r_timeout != c_TO_LAST)
                r_timeout <= r_timeout + TW'(1);
        end
    end

    // The quiet window only counts if the current cycle is idle as well.
    assign w_quiet_hit   = !i_cpu_active && (r_quiet == c_QUIET_LAST);
    assign w_timeout_hit = (r_timeout == c_TO_LAST);
    assign o_fire        = i_enable && (w_quiet_hit || w_timeout_hit);

endmodule
`default_nettype wire

// File: rtl/io_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : io_update_sched
// Purpose  : Issues one UPDATE pulse per I/O chip per VBLANK in a quiet bus
//            window, and arbitrates the CPU port onto the two chips.
// Revision : 1.0
// ============================================================================
module io_update_sched
    import io_pkg::*;
#(
    parameter int HOLDOFF = 4,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VBLANK,
    input  logic [1:0] CPU_CS,
    input  logic       CPU_WR,
    input  logic [5:0] CPU_ADRS,
    input  logic [7:0] CPU_DIN,
    output logic [7:0] CPU_DOUT,
    output logic       CPU_WAIT,
    input  logic [7:0] IO_DOUT0,
    input  logic [7:0] IO_DOUT1,
    output logic [1:0] CHIP_ENABLE,
    output logic       CHIP_WR,
    output logic [5:0] CHIP_ADRS,
    output logic [7:0] CHIP_DIN,
    output logic [1:0] CHIP_UPDATE,
    output logic       BUSY,
    output logic [7:0] OVERRUN
);

    localparam int GW = $clog2(GAP + 1);
    localparam logic [GW-1:0] c_GAP_LAST = GW'(GAP - 1);

    io_state_t     r_state;
    io_state_t     w_state_nxt;
    logic          r_vb_d;
    logic          r_pending;
    logic [7:0]    r_overrun;
    logic [GW-1:0] r_gap;
    logic [1:0]    r_rd_sel;

    logic          w_vb_rise;
    logic          w_start;
    logic          w_fire;
    logic          w_gap_done;
    logic          w_in_gap;
    logic [1:0]    w_update;
    logic [1:0]    w_sel;
    logic [1:0]    w_mask;

    assign w_vb_rise  = VBLANK && !r_vb_d;
    assign w_start    = (r_state == ST_IDLE) && r_pending;
    assign w_in_gap   = (r_state == ST_GAP0) || (r_state == ST_GAP1);
    assign w_gap_done = (r_gap == c_GAP_LAST);

    io_quiet_timer #(
        .HOLDOFF (HOLDOFF),
        .TIMEOUT (TIMEOUT)
    ) u_quiet_timer (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_clear      (w_start),
        .i_enable     (r_state == ST_WAIT_QUIET),
        .i_cpu_active (|CPU_CS),
        .o_fire       (w_fire)
    );

    // A request that arrives while one is pending or running is merged and
    // only counted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vb_d    <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 8'd0;
        end else begin
            r_vb_d <= VBLANK;
            if (w_start)
                r_pending <= 1'b0;
            else if (w_vb_rise)
                r_pending <= 1'b1;
            if (w_vb_rise && (r_pending || r_state != ST_IDLE) && r_overrun != 8'hFF)
                r_overrun <= r_overrun + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET || !w_in_gap)
            r_gap <= '0;
        else if (!w_gap_done)
            r_gap <= r_gap + GW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_update    = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (r_pending)
                    w_state_nxt = ST_WAIT_QUIET;
            end
            ST_WAIT_QUIET: begin
                if (w_fire)
                    w_state_nxt = ST_UPD0;
            end
            ST_UPD0: begin
                w_update[CHIP0] = 1'b1;
                w_state_nxt     = ST_GAP0;
            end
            ST_GAP0: begin
                if (w_gap_done)
                    w_state_nxt = ST_UPD1;
            end
            ST_UPD1: begin
                w_update[CHIP1] = 1'b1;
                w_state_nxt     = ST_GAP1;
            end
            ST_GAP1: begin
                if (w_gap_done)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign CHIP_UPDATE = w_update;
    assign BUSY        = (r_state != ST_IDLE);
    assign OVERRUN     = r_overrun;

    // Chip 0 has priority; the chip being updated this cycle is held off.
    always_comb begin
        w_sel        = 2'b00;
        w_sel[CHIP0] = CPU_CS[CHIP0];
        w_sel[CHIP1] = CPU_CS[CHIP1] && !CPU_CS[CHIP0];
        w_mask       = {r_state == ST_UPD1, r_state == ST_UPD0};
        CHIP_ENABLE  = w_sel & ~w_mask;
        CPU_WAIT     = |(w_sel & w_mask);
    end

    assign CHIP_WR   = CPU_WR;
    assign CHIP_ADRS = CPU_ADRS;
    assign CHIP_DIN  = CPU_DIN;

    always_ff @(posedge CLK) begin
        if (RESET)
            r_rd_sel <= 2'b00;
        else
            r_rd_sel <= CHIP_ENABLE;
    end

    always_comb begin
        CPU_DOUT = IDLE_READ;
        if (r_rd_sel[CHIP0])
            CPU_DOUT = IO_DOUT0;
        else if (r_rd_sel[CHIP1])
            CPU_DOUT = IO_DOUT1;
    end

endmodule
`default_nettype wire
